// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared pipeline defines (stage indices, StallBus width, FSM states).
package pipe_ctrl_pkg;
  localparam int IF_IDX  = 0;
  localparam int ID_IDX  = 1;
  localparam int EX_IDX  = 2;
  localparam int MEM_IDX = 3;
  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_e;
  function automatic int stall_bus_w(input int nstage);
    return nstage + 1;
  endfunction
  function automatic int wb_idx(input int nstage);
    return nstage - 1;
  endfunction
endpackage

// File: rtl/pipe_sat_cnt.sv
// pipe_sat_cnt: saturating up-counter with enable and synchronous active-low clear.
module pipe_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_n,
  input  logic         en,
  output logic [W-1:0] q
);
  logic [W-1:0] cnt_d, cnt_q;
  always_comb cnt_d = !clr_n ? '0 : (en && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= !rst ? '0 : cnt_d;
  assign q = cnt_q;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with stall watchdog; rst is synchronous active-low.
// Optional performance counters enabled by defining PIPE_PERF_CNT_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE    = 5,
  parameter int PC_W      = 32,
  parameter int CNT_W     = 32,
  parameter int STALL_MAX = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NSTAGE-1:0]              stallreq,
  input  logic                           flush_req,
  input  logic [PC_W-1:0]                flush_pc,
  output logic [stall_bus_w(NSTAGE)-1:0] stall,
  output logic [NSTAGE-1:0]              flush,
  output logic                           new_pc_valid,
  output logic [PC_W-1:0]                new_pc,
  output logic                           stall_timeout,
  output logic [CNT_W-1:0]               perf_stall_cnt,
  output logic [CNT_W-1:0]               perf_flush_cnt
);
  localparam int WD_W = $clog2(STALL_MAX + 2);
  state_e state_d, state_q;
  logic [PC_W-1:0] new_pc_d, new_pc_q;
  logic timeout_d, timeout_q;
  logic [stall_bus_w(NSTAGE)-1:0] stall_raw;
  logic [WD_W-1:0] wd_q;
  // Bus bit g holds if any stage at or beyond g-1 requests a stall.
  for (genvar g = 0; g <= NSTAGE; g++) begin : g_stall
    assign stall_raw[g] = |(stallreq >> (g == 0 ? 0 : g - 1));
  end
  assign stall         = (rst && state_q == IDLE) ? stall_raw : '0;
  assign flush         = (rst && state_q == FLUSH) ? '1 : '0;
  assign new_pc_valid  = rst && state_q == FLUSH;
  assign new_pc        = new_pc_q;
  assign stall_timeout = timeout_q;
  always_comb begin
    state_d   = flush_req ? FLUSH : IDLE;
    new_pc_d  = flush_req ? flush_pc : new_pc_q;
    timeout_d = timeout_q | (stall[0] && wd_q == WD_W'(STALL_MAX));
  end
  always_ff @(posedge clk) begin
    state_q   <= !rst ? IDLE : state_d;
    new_pc_q  <= !rst ? '0 : new_pc_d;
    timeout_q <= !rst ? 1'b0 : timeout_d;
  end
  pipe_sat_cnt #(.W(WD_W)) u_wd (
    .clk(clk), .rst(rst), .clr_n(stall[0]), .en(stall[0]), .q(wd_q)
  );
`ifdef PIPE_PERF_CNT_EN
  pipe_sat_cnt #(.W(CNT_W)) u_perf_stall (
    .clk(clk), .rst(rst), .clr_n(1'b1), .en(stall[0] && state_q == IDLE), .q(perf_stall_cnt)
  );
  pipe_sat_cnt #(.W(CNT_W)) u_perf_flush (
    .clk(clk), .rst(rst), .clr_n(1'b1), .en(flush_req), .q(perf_flush_cnt)
  );
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table-driven directed bench for pipe_ctrl plus watchdog and reset sequences.
module tb_pipe_ctrl;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [4:0] stallreq;
  logic flush_req;
  logic [31:0] flush_pc;
  logic [5:0] stall;
  logic [4:0] flush;
  logic new_pc_valid;
  logic [31:0] new_pc;
  logic stall_timeout;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
  int n_tests = 0, n_fail = 0;

  pipe_ctrl #(.NSTAGE(5), .PC_W(32), .CNT_W(32), .STALL_MAX(4)) dut (
    .clk(clk), .rst(rst), .stallreq(stallreq), .flush_req(flush_req), .flush_pc(flush_pc),
    .stall(stall), .flush(flush), .new_pc_valid(new_pc_valid), .new_pc(new_pc),
    .stall_timeout(stall_timeout), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic [4:0] sr; logic fr; logic [31:0] pc;
    logic [5:0] st; logic [4:0] fl; logic npv; logic [31:0] npc; logic to; int ps; int pf;
  } vec_t;
  vec_t v [14];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [4:0] sr, input logic fr, input logic [31:0] pc);
    @(posedge clk);
    #1;
    rst = r; stallreq = sr; flush_req = fr; flush_pc = pc;
    #1;
  endtask

  function automatic int pv(input int n);
    return PE ? n : 0;
  endfunction

  initial begin
    //          rst sr        fr  pc            stall      flush     npv  new_pc        to    ps      pf
    v[0]  = '{1'b0, 5'b11111, 1'b1, 32'hDEAD0000, 6'b000000, 5'b00000, 1'b0, 32'h0,        1'b0, pv(0), pv(0)};
    v[1]  = '{1'b1, 5'b00010, 1'b0, 32'h0,        6'b000111, 5'b00000, 1'b0, 32'h0,        1'b0, pv(0), pv(0)};
    v[2]  = '{1'b1, 5'b10010, 1'b0, 32'h0,        6'b111111, 5'b00000, 1'b0, 32'h0,        1'b0, pv(1), pv(0)};
    v[3]  = '{1'b1, 5'b00000, 1'b0, 32'h0,        6'b000000, 5'b00000, 1'b0, 32'h0,        1'b0, pv(2), pv(0)};
    v[4]  = '{1'b1, 5'b00000, 1'b1, 32'hBFC00380, 6'b000000, 5'b00000, 1'b0, 32'h0,        1'b0, pv(2), pv(0)};
    v[5]  = '{1'b1, 5'b00001, 1'b0, 32'h0,        6'b000000, 5'b11111, 1'b1, 32'hBFC00380, 1'b0, pv(2), pv(1)};
    v[6]  = '{1'b1, 5'b00000, 1'b0, 32'h0,        6'b000000, 5'b00000, 1'b0, 32'hBFC00380, 1'b0, pv(2), pv(1)};
    v[7]  = '{1'b1, 5'b00100, 1'b1, 32'h100,      6'b001111, 5'b00000, 1'b0, 32'hBFC00380, 1'b0, pv(2), pv(1)};
    v[8]  = '{1'b1, 5'b00000, 1'b1, 32'h200,      6'b000000, 5'b11111, 1'b1, 32'h100,      1'b0, pv(3), pv(2)};
    v[9]  = '{1'b1, 5'b00000, 1'b0, 32'h0,        6'b000000, 5'b11111, 1'b1, 32'h200,      1'b0, pv(3), pv(3)};
    v[10] = '{1'b1, 5'b00000, 1'b0, 32'h0,        6'b000000, 5'b00000, 1'b0, 32'h200,      1'b0, pv(3), pv(3)};
    v[11] = '{1'b1, 5'b00000, 1'b1, 32'h300,      6'b000000, 5'b00000, 1'b0, 32'h200,      1'b0, pv(3), pv(3)};
    v[12] = '{1'b0, 5'b01000, 1'b0, 32'h0,        6'b000000, 5'b00000, 1'b0, 32'h300,      1'b0, pv(3), pv(4)};
    v[13] = '{1'b1, 5'b00000, 1'b0, 32'h0,        6'b000000, 5'b00000, 1'b0, 32'h0,        1'b0, pv(0), pv(0)};
    rst = 1'b0; stallreq = '0; flush_req = 1'b0; flush_pc = '0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 14; i++) begin
      step(v[i].rst, v[i].sr, v[i].fr, v[i].pc);
      chk("stall", i, 32'(stall), 32'(v[i].st));
      chk("flush", i, 32'(flush), 32'(v[i].fl));
      chk("new_pc_valid", i, 32'(new_pc_valid), 32'(v[i].npv));
      chk("new_pc", i, new_pc, v[i].npc);
      chk("stall_timeout", i, 32'(stall_timeout), 32'(v[i].to));
      chk("perf_stall_cnt", i, perf_stall_cnt, v[i].ps);
      chk("perf_flush_cnt", i, perf_flush_cnt, v[i].pf);
    end
    // Watchdog: STALL_MAX=4, flag appears once five stalled cycles have completed.
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 5'b00001, 1'b0, 32'h0);
      chk("wd_before", c, 32'(stall_timeout), 32'(1'b0));
    end
    step(1'b1, 5'b00001, 1'b0, 32'h0);
    chk("wd_set", 0, 32'(stall_timeout), 32'(1'b1));
    chk("wd_perf_stall", 0, perf_stall_cnt, pv(5));
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 5'b00000, 1'b0, 32'h0);
      chk("wd_sticky", c, 32'(stall_timeout), 32'(1'b1));
    end
    chk("wd_perf_stall_final", 0, perf_stall_cnt, pv(6));
    step(1'b0, 5'b00000, 1'b0, 32'h0);
    step(1'b1, 5'b00000, 1'b0, 32'h0);
    chk("wd_reset", 0, 32'(stall_timeout), 32'(1'b0));
    chk("perf_stall_reset", 0, perf_stall_cnt, 32'h0);
    // Short stall bursts broken by idle cycles must not trip the watchdog.
    for (int c = 0; c < 3; c++) begin
      repeat (4) step(1'b1, 5'b10000, 1'b0, 32'h0);
      step(1'b1, 5'b00000, 1'b0, 32'h0);
    end
    step(1'b1, 5'b00000, 1'b0, 32'h0);
    chk("wd_clear_between", 0, 32'(stall_timeout), 32'(1'b0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter NSTAGE, default 5: number of pipeline stages (index 0 = IF ... NSTAGE-1 = WB); legal range 3..8.
REQ-002 Parameter PC_W, default 32: width of the flush target PC.
REQ-003 Parameter CNT_W, default 32: width of each performance counter.
REQ-004 Parameter STALL_MAX, default 255: longest legal continuous stall, in cycles.
REQ-005 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous and active-low.
REQ-007 Port stallreq, input, NSTAGE: bit k set means stage k requests a stall this cycle.
REQ-008 Port flush_req, input, 1: one-cycle request to flush the pipeline.
REQ-009 Port flush_pc, input, PC_W: redirect target, valid only with flush_req.
REQ-010 Port stall, output, NSTAGE+1: bit 0 = PC register hold; bit k+1 = stage-k register hold.
REQ-011 Port flush, output, NSTAGE: bit k clears the valid bit of stage k.
REQ-012 Port new_pc_valid, output, 1: the PC register loads new_pc this cycle.
REQ-013 Port new_pc, output, PC_W: the registered flush target.
REQ-014 Port stall_timeout, output, 1: sticky flag for a stall watchdog overrun.
REQ-015 Port perf_stall_cnt, output, CNT_W: count of stalled cycles.
REQ-016 Port perf_flush_cnt, output, CNT_W: count of flushes.

Function
REQ-017 Let k be the highest set index of stallreq. The block SHALL drive stall[k+1:0] to all ones and the remaining stall bits to 0, combinationally with zero latency.
REQ-018 When stallreq is 0, stall SHALL be 0.
REQ-019 The FSM SHALL have two states, IDLE and FLUSH; flush_req in any state SHALL move the FSM to FLUSH on the next edge and latch flush_pc into new_pc on that edge.
REQ-020 In FLUSH with no flush_req, the FSM SHALL return to IDLE on the next edge.
REQ-021 Back-to-back flush_req SHALL keep the FSM in FLUSH, and new_pc SHALL take the newest target.
REQ-022 In FLUSH, flush SHALL be all ones, new_pc_valid SHALL be 1, and stall SHALL be forced to 0 (flush overrides stall).
REQ-023 In IDLE, flush SHALL be 0 and new_pc_valid SHALL be 0.
REQ-024 If flush_req and stallreq are asserted in the same cycle, stall SHALL apply in that cycle and the flush SHALL follow in the next cycle.
REQ-025 A watchdog counter SHALL increment on each cycle with stall[0]=1 and SHALL clear on any cycle with stall[0]=0.
REQ-026 When the watchdog reaches STALL_MAX+1, stall_timeout SHALL set and remain set until reset.
REQ-027 The watchdog counter SHALL saturate rather than wrap.

Reset
REQ-028 While rst=0 at a clock edge, the FSM SHALL enter IDLE, and new_pc, the watchdog, stall_timeout and both counters SHALL clear to 0.
REQ-029 While rst=0, stall, flush and new_pc_valid SHALL be driven to 0 regardless of the inputs.
REQ-030 Reset asserted during FLUSH SHALL abort the flush, with no new_pc_valid in the following cycle.

Configuration
REQ-031 With macro PIPE_PERF_CNT_EN defined, perf_stall_cnt SHALL increment on each IDLE cycle with stall[0]=1.
REQ-032 With PIPE_PERF_CNT_EN defined, perf_flush_cnt SHALL increment on each edge that enters or re-enters FLUSH.
REQ-033 With PIPE_PERF_CNT_EN defined, both counters SHALL saturate at all ones.
REQ-034 Without PIPE_PERF_CNT_EN, both counter outputs SHALL be constant 0 and no counter flops SHALL be synthesised.

Structure
REQ-035 The stage-index constants and the StallBus width (NSTAGE+1) SHALL live in the shared defines file used by all pipeline stages.
REQ-036 A sub-module pipe_sat_cnt (saturating counter with enable and synchronous active-low clear) SHALL implement the watchdog and both performance counters.

Verification
REQ-037 Directed test, stall encoding: NSTAGE=5, stallreq=5'b00010 -> stall=6'b000111 in the same cycle; stallreq=5'b10010 -> stall=6'b111111.
REQ-038 Directed test, single flush: flush_req with flush_pc=32'hBFC00380 -> next cycle FSM in FLUSH, flush=5'b11111, new_pc_valid=1, new_pc=32'hBFC00380; the following cycle flush=0.
REQ-039 Directed test, flush with stall: flush_req with stallreq=5'b00100 in cycle N -> cycle N stall=6'b001111; cycle N+1 stall=0, flush=all ones.
REQ-040 Directed test, back-to-back flush: flush_pc=0x100 then 0x200 on consecutive cycles -> FLUSH held two cycles, new_pc 0x100 then 0x200, perf_flush_cnt=2.
REQ-041 Directed test, watchdog: STALL_MAX=4 and stall[0] held high -> stall_timeout rises on the 5th stalled cycle and stays high after stallreq drops; perf_stall_cnt=stalled-cycle count.
REQ-042 Directed test, reset mid-flush: rst=0 in the FLUSH cycle -> next cycle state IDLE, new_pc_valid=0, all counters 0.
